// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding
// and register-file index constants.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam int                   REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0    = '0;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. Writes to x0 never create a dependency.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 uses_rs1,
  input  logic                 uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 lu
);

  logic [REG_IDX_W-1:0] src [2];
  logic [1:0]           uses;
  logic [1:0]           hit;

  assign src[0] = rs1;
  assign src[1] = rs2;
  assign uses   = {uses_rs2, uses_rs1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hit[gi] = uses[gi] && (src[gi] == ex_rd);
    end
  endgenerate

  assign lu = ex_mem_read && (ex_rd != REG_X0) && (|hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, memory-wait
// freeze and taken-branch squash. Perf counters exist only with HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] IF_ID_RS1,
  input  logic [REG_IDX_W-1:0] IF_ID_RS2,
  input  logic                 IF_ID_UsesRS1,
  input  logic                 IF_ID_UsesRS2,
  input  logic [REG_IDX_W-1:0] ID_EX_RD,
  input  logic                 ID_EX_MemRead,
  input  logic                 EX_MEM_MemAccess,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 ID_EX_Bubble,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic                 Pipe_Hold,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  hz_state_t  state_reg;
  logic       flush_pending_reg;
  logic [7:0] wait_cnt_reg;
  logic       mem_timeout_reg;

  logic       lu;
  logic       ms;
  logic       hold;
  logic       flush_req;
  logic [7:0] wait_cnt_next;

  load_use_detect u_lu (
    .rs1         (IF_ID_RS1),
    .rs2         (IF_ID_RS2),
    .uses_rs1    (IF_ID_UsesRS1),
    .uses_rs2    (IF_ID_UsesRS2),
    .ex_rd       (ID_EX_RD),
    .ex_mem_read (ID_EX_MemRead),
    .lu          (lu)
  );

  assign ms            = EX_MEM_MemAccess && !mem_ready;
  // In MEM_WAIT only mem_ready releases the freeze, whatever MEM currently shows.
  assign hold          = (state_reg == RUN) ? ms : !mem_ready;
  assign flush_req     = branch_taken || ((state_reg == MEM_WAIT) && flush_pending_reg);
  assign wait_cnt_next = (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    Pipe_Hold    = 1'b0;
    if (!rst_n) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (hold) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      Pipe_Hold   = 1'b1;
    end else if (flush_req) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (lu) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= RUN;
      flush_pending_reg <= 1'b0;
      wait_cnt_reg      <= 8'd0;
      mem_timeout_reg   <= 1'b0;
    end else if (state_reg == RUN) begin
      wait_cnt_reg <= 8'd0;
      if (ms) begin
        state_reg         <= MEM_WAIT;
        flush_pending_reg <= branch_taken;
      end else begin
        flush_pending_reg <= 1'b0;
      end
    end else begin
      if (mem_ready) begin
        state_reg         <= RUN;
        wait_cnt_reg      <= 8'd0;
        flush_pending_reg <= 1'b0;
      end else begin
        wait_cnt_reg      <= wait_cnt_next;
        flush_pending_reg <= flush_pending_reg || branch_taken;
        if (wait_cnt_next >= TIMEOUT_LIM)
          mem_timeout_reg <= 1'b1;
      end
    end
  end

  assign mem_timeout = mem_timeout_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [CNT_W-1:0] flush_events_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      if (!PC_Write)
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      if (IF_ID_Flush)
        flush_events_reg <= flush_events_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues expected control vectors,
// a negedge monitor pops and compares them along with the perf counters.
module tb_hazard_ctrl;

  localparam int CNT_W = 32;

  // Packed as {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, Pipe_Hold, mem_timeout}
  localparam logic [6:0] IDLE = 7'b1100000;
  localparam logic [6:0] HOLD = 7'b0000010;
  localparam logic [6:0] BUB  = 7'b0010000;
  localparam logic [6:0] FLS  = 7'b1101100;
  localparam logic [6:0] RSTV = 7'b0001100;
  localparam logic [6:0] TO   = 7'b0000001;

  logic             clk;
  logic             rst_n;
  logic [4:0]       if_id_rs1, if_id_rs2, id_ex_rd;
  logic             uses_rs1, uses_rs2, id_ex_memread;
  logic             ex_mem_access, mem_ready, branch_taken;
  logic             pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, pipe_hold, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_ID_RS1        (if_id_rs1),
    .IF_ID_RS2        (if_id_rs2),
    .IF_ID_UsesRS1    (uses_rs1),
    .IF_ID_UsesRS2    (uses_rs2),
    .ID_EX_RD         (id_ex_rd),
    .ID_EX_MemRead    (id_ex_memread),
    .EX_MEM_MemAccess (ex_mem_access),
    .mem_ready        (mem_ready),
    .branch_taken     (branch_taken),
    .PC_Write         (pc_write),
    .IF_ID_Write      (if_id_write),
    .ID_EX_Bubble     (id_ex_bubble),
    .IF_ID_Flush      (if_id_flush),
    .ID_EX_Flush      (id_ex_flush),
    .Pipe_Hold        (pipe_hold),
    .mem_timeout      (mem_timeout),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );

  typedef struct {
    string      nm;
    logic [6:0] ctl;
    logic       rn;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d entries still queued", q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: DUT outputs are combinational, so they are sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [6:0] act;
      int         es, ef;
      e   = q.pop_front();
      act = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, pipe_hold, mem_timeout};
      n_tests++;
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL %s: ctl got %b expected %b", e.nm, act, e.ctl);
      end else
        $display("[TB] %s: ctl %b ok", e.nm, act);
`ifdef HAZARD_PERF_CNT_EN
      es = e.rn ? exp_stall : 0;
      ef = e.rn ? exp_flush : 0;
`else
      es = 0;
      ef = 0;
`endif
      n_tests++;
      if (stall_cycles !== CNT_W'(es) || flush_events !== CNT_W'(ef)) begin
        n_fail++;
        $display("FAIL %s_cnt: stall/flush got %0d/%0d expected %0d/%0d",
                 e.nm, stall_cycles, flush_events, es, ef);
      end
      if (!e.rn) begin
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        exp_stall += (e.ctl[6] == 1'b0) ? 1 : 0;
        exp_flush += (e.ctl[3] == 1'b1) ? 1 : 0;
      end
    end
  end

  task automatic drive(input string nm, input logic rn,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic ma, input logic rdy, input logic br,
                       input logic [6:0] ctl);
    exp_t e;
    rst_n         = rn;
    if_id_rs1     = rs1;
    if_id_rs2     = rs2;
    uses_rs1      = u1;
    uses_rs2      = u2;
    id_ex_rd      = rd;
    id_ex_memread = mr;
    ex_mem_access = ma;
    mem_ready     = rdy;
    branch_taken  = br;
    e.nm  = nm;
    e.ctl = ctl;
    e.rn  = rn;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Memory-side helper: ID/EX quiet, only MEM access/ready/branch vary.
  task automatic mem(input string nm, input logic ma, input logic rdy, input logic br,
                     input logic [6:0] ctl);
    drive(nm, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, ma, rdy, br, ctl);
  endtask

  initial begin
    rst_n = 1'b0;
    if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rd = '0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; id_ex_memread = 1'b0;
    ex_mem_access = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;

    drive("rst0", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV);
    drive("rst1", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV);
    mem("idle", 0, 0, 0, IDLE);

    drive("lu_rs2",   1'b1, 0, 5, 0, 1, 5, 1, 0, 0, 0, BUB);
    drive("lu_after", 1'b1, 0, 5, 0, 1, 5, 0, 0, 0, 0, IDLE);
    drive("lu_rs1",   1'b1, 7, 0, 1, 0, 7, 1, 0, 0, 0, BUB);
    drive("lu_nouse", 1'b1, 7, 0, 0, 0, 7, 1, 0, 0, 0, IDLE);
    drive("lu_x0",    1'b1, 0, 0, 1, 1, 0, 1, 0, 0, 0, IDLE);
    drive("br_lu",    1'b1, 5, 0, 1, 0, 5, 1, 0, 0, 1, FLS);

    // Store waits 3 cycles (entry has a load-use too, which the freeze outranks).
    drive("ms_lu",    1'b1, 5, 0, 1, 0, 5, 1, 1, 0, 0, HOLD);
    mem("mw1", 1, 0, 0, HOLD);
    mem("mw2", 1, 0, 0, HOLD);
    mem("rel", 1, 1, 0, IDLE);

    mem("br_enter", 1, 0, 1, HOLD);
    mem("rel_fp",   1, 1, 0, FLS);
    mem("fp_clear", 0, 0, 0, IDLE);

    mem("ent2",    1, 0, 0, HOLD);
    mem("mw_br",   1, 0, 1, HOLD);
    mem("mw_a",    1, 0, 0, HOLD);
    mem("rel_fp2", 1, 1, 0, FLS);
    mem("idle2",   0, 0, 0, IDLE);

    mem("ent3",   1, 0, 0, HOLD);
    mem("rel_br", 1, 1, 1, FLS);
    mem("idle3",  0, 0, 0, IDLE);

    mem("ent4", 1, 0, 0, HOLD);
    drive("rel_lu", 1'b1, 5, 0, 1, 0, 5, 1, 1, 1, 0, BUB);
    mem("idle4", 0, 0, 0, IDLE);

    // Timeout limit is 4: flag appears after the fourth MEM_WAIT cycle.
    mem("ent5", 1, 0, 0, HOLD);
    for (int i = 1; i <= 4; i++)
      mem($sformatf("wait%0d", i), 1, 0, 0, HOLD);
    mem("to_set",    1, 0, 0, HOLD | TO);
    mem("to_rel",    1, 1, 0, IDLE | TO);
    mem("to_sticky", 0, 0, 0, IDLE | TO);

    mem("ent6", 1, 0, 0, HOLD | TO);
    mem("mw6",  1, 0, 0, HOLD | TO);
    drive("rst_mw0", 1'b0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTV);
    drive("rst_mw1", 1'b0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTV);
    mem("post_rst0", 0, 0, 0, IDLE);
    mem("post_rst1", 0, 0, 0, IDLE);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core; the stall/flush side of the data-hazard mechanism, complementing operand forwarding. It detects load-use hazards that forwarding cannot resolve and inserts a single bubble. It also freezes the pipeline while a data-memory access is outstanding, and squashes wrong-path instructions on a taken branch, holding that squash pending across a memory wait. It sits beside the pipeline registers and drives their write-enable and flush controls.

## Interface
Parameters:
- MEM_TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before `mem_timeout` is raised; range 2..255.
- CNT_W, 32, width of performance counters (used only with the perf macro).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- IF_ID_RS1  in  5  rs1 of the instruction in ID.
- IF_ID_RS2  in  5  rs2 of the instruction in ID.
- IF_ID_UsesRS1  in  1  ID instruction reads rs1.
- IF_ID_UsesRS2  in  1  ID instruction reads rs2.
- ID_EX_RD  in  5  destination register of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_MEM_MemAccess  in  1  instruction in MEM issues a load or store.
- mem_ready  in  1  data memory completes the current access this cycle.
- branch_taken  in  1  EX resolves a taken branch or jump this cycle.
- PC_Write  out  1  PC register enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Bubble  out  1  load zeroed control bits into ID/EX.
- IF_ID_Flush  out  1  clear IF/ID to NOP.
- ID_EX_Flush  out  1  clear ID/EX to NOP.
- Pipe_Hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  CNT_W  perf counter (macro only).
- flush_events  out  CNT_W  perf counter (macro only).

## Operation
- States: RUN, MEM_WAIT. Registers: `state`, `flush_pending`, `wait_cnt` (8 bit), `mem_timeout`.
- Load-use hazard `lu`: ID_EX_MemRead && ID_EX_RD != 0, and either (UsesRS1 && RS1 == ID_EX_RD) or (UsesRS2 && RS2 == ID_EX_RD).
- Memory stall `ms`: EX_MEM_MemAccess && !mem_ready.
- Output priority per cycle: `ms` > flush > `lu` > normal.
- RUN, `ms`: Pipe_Hold=1, PC_Write=0, IF_ID_Write=0, no flush, no bubble. Next state is MEM_WAIT. If branch_taken, set flush_pending.
- RUN, no `ms`, branch_taken: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1. `lu` is ignored because the dependent instruction is squashed.
- RUN, `lu` only: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly one cycle. The bubble clears ID_EX_MemRead, so no second stall occurs.
- MEM_WAIT: same freeze outputs as `ms`; `wait_cnt` increments each cycle.
  - mem_ready=1: return to RUN that cycle. Outputs that cycle are computed as in RUN with `ms`=0. A set flush_pending is treated as branch_taken, then cleared.
  - wait_cnt reaches MEM_TIMEOUT: set `mem_timeout`. It stays set until reset. The FSM stays in MEM_WAIT.
- `wait_cnt` clears on entry to RUN and saturates at 255.
- Idle outputs: PC_Write=1, IF_ID_Write=1, all other controls 0.

## Timing
- All outputs are combinational from current state, registers and inputs, so stalls and flushes take effect at the next edge with zero added latency.
- Load-use penalty: exactly 1 cycle.
- Taken-branch penalty: 2 squashed instructions, flushed in a single cycle.
- Memory wait: hold lasts for every cycle with mem_ready=0, including the entry cycle.
- mem_ready and branch_taken arriving in the same MEM_WAIT cycle: release and flush in that same cycle.
- Reset asserted, including mid MEM_WAIT:
  - state=RUN; flush_pending, wait_cnt, mem_timeout and counters all 0.
  - Outputs forced to PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, ID_EX_Bubble=0, Pipe_Hold=0.
- First edge after deassert: idle outputs.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - `stall_cycles` increments on every cycle with PC_Write=0.
  - `flush_events` increments on every cycle with IF_ID_Flush=1.
  - Both outside reset, wrap modulo 2^CNT_W.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared pipeline package holds:
  - the state enum (RUN=1'b0, MEM_WAIT=1'b1);
  - the register-index width constant (5);
  - the x0 index constant.
- One sub-module, `load_use_detect`: purely the `lu` comparator. The FSM, priority and counters stay in `hazard_ctrl`.

## Test plan
- Load to x5 in EX, ID reads x5 as rs2 with UsesRS2=1 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, then idle.
- Load to x0 in EX, ID reads x0 -> no stall.
- Store in MEM, mem_ready low for 3 cycles -> Pipe_Hold=1 for 3 cycles, release on the 4th.
- branch_taken during MEM_WAIT, mem_ready rises 2 cycles later -> IF_ID_Flush and ID_EX_Flush high exactly on the release cycle.
- MEM_TIMEOUT=4, mem_ready held low -> mem_timeout rises after 4 wait cycles and stays set after mem_ready returns.
- rst_n low mid MEM_WAIT -> outputs hold their reset values; after release the FSM is in RUN with idle outputs and counters 0.
